// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deserializes 11-bit device-to-host frames,
// validates start/parity/stop and queues good scan codes in a small FIFO.
module ps2_keyboard_rx #(
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  localparam int Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};

  logic [2:0]       r_ps2ClkSync;
  logic [9:0]       r_buffer;
  logic [3:0]       r_count;
  logic [7:0]       r_fifo [Depth];
  logic [FIFO_AW:0] r_wPtr;
  logic [FIFO_AW:0] r_rPtr;
  logic             r_overflow;

  logic w_fall;
  logic w_frameEnd;
  logic w_frameValid;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_fall       = r_ps2ClkSync[2] && !r_ps2ClkSync[1];
  assign w_frameEnd   = w_fall && (r_count == 4'd10);
  // The stop bit is the live ps2_data at this edge; it is never stored.
  assign w_frameValid = !r_buffer[0] && ps2_data && (^r_buffer[9:1]);
  assign w_full       = (r_wPtr[FIFO_AW-1:0] == r_rPtr[FIFO_AW-1:0]) &&
                        (r_wPtr[FIFO_AW] != r_rPtr[FIFO_AW]);
  assign w_push       = w_frameEnd && w_frameValid && !w_full;
  assign w_pop        = !nextdata_n && ready;

  assign ready    = (r_wPtr != r_rPtr);
  assign data     = ready ? r_fifo[r_rPtr[FIFO_AW-1:0]] : 8'h00;
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ps2ClkSync <= 3'b111;
      r_count      <= 4'd0;
      r_buffer     <= 10'd0;
    end else begin
      r_ps2ClkSync <= {r_ps2ClkSync[1:0], ps2_clk};
      if (w_fall) begin
        if (r_count == 4'd10) begin
          r_count <= 4'd0;
        end else begin
          r_buffer[r_count] <= ps2_data;
          r_count           <= r_count + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wPtr     <= '0;
      r_rPtr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wPtr <= r_wPtr + PtrOne;
      end
      if (w_pop) begin
        r_rPtr <= r_rPtr + PtrOne;
      end
      // Fullness is judged before any same-cycle pop, so the byte is lost.
      if (w_frameEnd && w_frameValid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wPtr[FIFO_AW-1:0]] <= r_buffer[8:1];
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomized scoreboard bench for ps2_keyboard_rx: a keyboard model sends
// frames, expected bytes are queued, and a monitor pops and compares them.
module tb_ps2_keyboard_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] expQ [$];
  logic [7:0] monExp;
  bit         popEn       = 1'b0;
  bit         expOverflow = 1'b0;
  logic       readyBeforeWrite;
  logic       readyAfterWrite;
  logic [7:0] dataAfterWrite;

  ps2_keyboard_rx #(.FIFO_AW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Host side: pops one byte per cycle while enabled, checking each pop
  // against the oldest expected byte.
  always @(negedge clk) begin
    if (rst) begin
      nextdata_n = 1'b1;
    end else if (ready && popEn) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedByte: got %h, expected no byte", data);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("popData", data, monExp);
      end
      nextdata_n = 1'b0;
    end else begin
      nextdata_n = 1'b1;
    end
  end

  // kind: 0 good, 1 bad parity, 2 bad start, 3 bad stop.
  task automatic applyStimulus(input logic [7:0] value, input int kind,
                               input int nBits);
    logic [10:0] bits;
    bits[0]   = (kind == 2);
    bits[8:1] = value;
    bits[9]   = (($countones(value) % 2) == 0) ^ (kind == 1);
    bits[10]  = (kind != 3);
    for (int i = 0; i < nBits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat ($urandom_range(3, 8)) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        if (kind == 0) begin
          if (expQ.size() < 8) expQ.push_back(value);
          else expOverflow = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 readyBeforeWrite = ready;
        @(posedge clk);
        #1 readyAfterWrite = ready;
        dataAfterWrite = data;
        @(negedge clk);
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end else begin
        repeat ($urandom_range(4, 8)) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    expQ.delete();
    expOverflow = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    popEn = 1'b1;
    @(posedge clk);
    #1;
    while ((expQ.size() != 0 || ready) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    compared++;
    if (n >= 200) begin
      mismatched++;
      $display("[TB] FAIL %s: drain timed out with %0d bytes pending, expected 0",
               name, expQ.size());
    end
    checkOutput({name, "Ready"}, {7'd0, ready}, 8'd0);
  endtask

  logic [7:0] burst [8] = '{8'h1C, 8'hF0, 8'h1C, 8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};

  initial begin
    rst        = 1'b1;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    applyReset();
    checkOutput("resetReady", {7'd0, ready}, 8'd0);
    checkOutput("resetData", data, 8'h00);
    checkOutput("resetOverflow", {7'd0, overflow}, 8'd0);

    popEn = 1'b0;
    applyStimulus(8'h1C, 0, 11);
    checkOutput("singleReadyBefore", {7'd0, readyBeforeWrite}, 8'd0);
    checkOutput("singleReadyAfter", {7'd0, readyAfterWrite}, 8'd1);
    checkOutput("singleData", dataAfterWrite, 8'h1C);
    waitDrain("single");

    for (int i = 0; i < 8; i++) applyStimulus(burst[i], 0, 11);
    waitDrain("burst");
    checkOutput("burstOverflow", {7'd0, overflow}, 8'd0);

    applyStimulus(8'h1C, 1, 11);
    applyStimulus(8'hF0, 3, 11);
    applyStimulus(8'h1B, 0, 11);
    waitDrain("badFrames");
    checkOutput("badFramesOverflow", {7'd0, overflow}, 8'd0);

    applyReset();
    popEn = 1'b0;
    for (int v = 1; v <= 9; v++) applyStimulus(v[7:0], 0, 11);
    checkOutput("fullOverflow", {7'd0, overflow}, 8'd1);
    checkOutput("fullReady", {7'd0, ready}, 8'd1);
    checkOutput("fullHead", data, 8'h01);
    waitDrain("fullDrain");
    checkOutput("stickyOverflow", {7'd0, overflow}, 8'd1);
    applyReset();
    checkOutput("overflowCleared", {7'd0, overflow}, 8'd0);

    popEn = 1'b1;
    applyStimulus(8'h55, 0, 5);
    applyReset();
    applyStimulus(8'h1B, 0, 11);
    waitDrain("midReset");

    for (int n = 0; n < 40; n++) begin
      int r;
      popEn = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      applyStimulus($urandom_range(0, 255), (r < 7) ? 0 : r - 6, 11);
      checkOutput("randomOverflow", {7'd0, overflow}, {7'd0, expOverflow});
    end
    waitDrain("randomDrain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
